muldiv_sequencer: RTL

//  Iterative multiply/divide unit owning the HI/LO special-purpose registers.

---
 rtl/muldiv_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider owning HI/LO; start-to-done is WIDTH+1 cycles (1 for divide-by-zero).
// Start is ignored while busy and cancel aborts without a done pulse; define MULDIV_SIGNED_EN to add op_signed (two's-complement operands).
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MULDIV_SIGNED_EN
  input  logic             op_signed,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   acc_q;   // MUL upper accumulator / DIV partial remainder
  logic [WIDTH-1:0]   sh_q;    // MUL multiplier / DIV dividend shifting into quotient
  logic [WIDTH-1:0]   opnd_q;  // multiplicand or divisor magnitude
  logic               neg_hi_q;
  logic               neg_lo_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               sgn;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc_d;
  logic [WIDTH-1:0]   mul_sh_d;
  logic [2*WIDTH-1:0] mul_prod;
  logic [2*WIDTH-1:0] mul_res;

  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;
  logic               borrow;
  logic [WIDTH-1:0]   div_acc_d;
  logic [WIDTH-1:0]   div_sh_d;
  logic [WIDTH-1:0]   div_rem_res;
  logic [WIDTH-1:0]   div_quo_res;

`ifdef MULDIV_SIGNED_EN
  assign sgn = op_signed;
`else
  assign sgn = 1'b0;
`endif

  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_acc_d = mul_sum[WIDTH:1];
    mul_sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
    mul_prod  = {mul_acc_d, mul_sh_d};
    mul_res   = neg_hi_q ? -mul_prod : mul_prod;

    // rem_sh < 2*divisor, so bit WIDTH of the difference is exactly the borrow
    rem_sh      = {acc_q, sh_q[WIDTH-1]};
    div_diff    = rem_sh - {1'b0, opnd_q};
    borrow      = div_diff[WIDTH];
    div_acc_d   = borrow ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_sh_d    = {sh_q[WIDTH-2:0], ~borrow};
    div_rem_res = neg_hi_q ? -div_acc_d : div_acc_d;
    div_quo_res = neg_lo_q ? -div_sh_d : div_sh_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      opnd_q   <= '0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (cancel) begin
            state_q <= IDLE;
          end else if (start) begin
            dz_q <= 1'b0;
            if (op && (b == '0)) begin
              state_q <= DONE;
              hi_q    <= a;
              lo_q    <= '1;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q  <= op ? DIV : MUL;
              busy_q   <= 1'b1;
              cnt_q    <= CNT_W'(WIDTH);
              acc_q    <= '0;
              opnd_q   <= op ? b_mag : a_mag;
              sh_q     <= op ? a_mag : b_mag;
              neg_hi_q <= op ? a_neg : (a_neg ^ b_neg);
              neg_lo_q <= a_neg ^ b_neg;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        MUL: begin
          if (cancel) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= mul_acc_d;
            sh_q  <= mul_sh_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              hi_q    <= mul_res[2*WIDTH-1:WIDTH];
              lo_q    <= mul_res[WIDTH-1:0];
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DIV: begin
          if (cancel) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= div_acc_d;
            sh_q  <= div_sh_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              hi_q    <= div_rem_res;
              lo_q    <= div_quo_res;
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
